// File: rtl/d_cache_2way_wb.sv
// d_cache_2way_wb: two-way set-associative write-back, write-allocate data cache with per-set LRU.
// Core and bridge sides both use the sram-like req/addr_ok/data_ok handshake.
module d_cache_2way_wb #(
    parameter int INDEX_WIDTH     = 7,
    parameter int LINE_WORDS_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int SETS         = 1 << INDEX_WIDTH;
    localparam int LINE_WORDS   = 1 << LINE_WORDS_LOG2;
    localparam int OFFSET_WIDTH = LINE_WORDS_LOG2 + 2;
    localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int KW           = LINE_WORDS_LOG2 > 0 ? LINE_WORDS_LOG2 : 1;
    localparam int AW           = INDEX_WIDTH + LINE_WORDS_LOG2;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
    state_t state, state_next;

    logic [TAG_WIDTH-1:0]   tag_mem  [2][SETS];
    logic [31:0]            data_mem [2][SETS*LINE_WORDS];
    logic [1:0][SETS-1:0]   valid, dirty;
    logic [SETS-1:0]        lru;

    logic [KW-1:0]          k;
    logic                   addr_rcv;
    logic [TAG_WIDTH-1:0]   miss_tag;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic                   victim;

    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] cpu_index;
    logic [KW-1:0]          cpu_word;
    logic [AW-1:0]          cpu_addr_w, miss_addr_w, mem_addr;
    logic                   hit0, hit1, hit, hit_way, req_hit, req_miss;
    logic                   new_victim, bus_ok, last, fill_done, enter_fill;
    logic                   clr_way, mem_we, mem_way;
    logic [INDEX_WIDTH-1:0] clr_index;
    logic [3:0]             be;
    logic [31:0]            hit_word, merged, mem_wdata;

    assign cpu_tag     = cpu_data_addr[31 -: TAG_WIDTH];
    assign cpu_index   = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word    = KW'((cpu_data_addr >> 2) & 32'(LINE_WORDS - 1));
    assign cpu_addr_w  = (AW'(cpu_index) << LINE_WORDS_LOG2) | AW'(cpu_word);
    assign miss_addr_w = (AW'(miss_index) << LINE_WORDS_LOG2) | AW'(k);

    assign hit0     = valid[0][cpu_index] && tag_mem[0][cpu_index] == cpu_tag;
    assign hit1     = valid[1][cpu_index] && tag_mem[1][cpu_index] == cpu_tag;
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign req_hit  = state == IDLE && cpu_data_req && hit;
    assign req_miss = state == IDLE && cpu_data_req && !hit;
    assign hit_word = data_mem[hit_way][cpu_addr_w];

    assign new_victim = !valid[0][cpu_index] ? 1'b0 : !valid[1][cpu_index] ? 1'b1 : lru[cpu_index];
    assign bus_ok     = state != IDLE && cache_data_data_ok;
    assign last       = k == KW'(LINE_WORDS - 1);
    assign fill_done  = state == FILL && bus_ok && last;
    assign enter_fill = state_next == FILL && state != FILL;
    // From IDLE the victim is not latched yet, so take it straight from the lookup.
    assign clr_way    = state == IDLE ? new_victim : victim;
    assign clr_index  = state == IDLE ? cpu_index : miss_index;

    assign be = cpu_data_size == 2'd0 ? 4'b0001 << cpu_data_addr[1:0] :
                cpu_data_size == 2'd1 ? (cpu_data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_comb begin
        merged = hit_word;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? cpu_data_wdata[8*i +: 8] : hit_word[8*i +: 8];
    end

    assign mem_we    = (req_hit && cpu_data_wr) || (state == FILL && bus_ok);
    assign mem_way   = state == FILL ? victim : hit_way;
    assign mem_addr  = state == FILL ? miss_addr_w : cpu_addr_w;
    assign mem_wdata = state == FILL ? cache_data_rdata : merged;

    always_ff @(posedge clk) begin
        if (mem_we)
            data_mem[mem_way][mem_addr] <= mem_wdata;
        if (fill_done)
            tag_mem[victim][miss_index] <= miss_tag;
        if (req_miss) begin
            miss_tag   <= cpu_tag;
            miss_index <= cpu_index;
            victim     <= new_victim;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = !req_miss ? IDLE :
                         (valid[new_victim][cpu_index] && dirty[new_victim][cpu_index]) ? WB : FILL;
        else if (bus_ok && last)
            state_next = state == WB ? FILL : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            addr_rcv <= 1'b0;
            valid    <= '0;
            dirty    <= '0;
            lru      <= '0;
        end else begin
            if (bus_ok)
                k <= last ? '0 : k + KW'(1);
            // A same-cycle addr_ok/data_ok completes the word, so data_ok wins.
            addr_rcv <= bus_ok ? 1'b0 : (cache_data_req && cache_data_addr_ok) ? 1'b1 : addr_rcv;
            if (req_hit)
                lru[cpu_index] <= ~hit_way;
            if (req_hit && cpu_data_wr)
                dirty[hit_way][cpu_index] <= 1'b1;
            if (enter_fill)
                valid[clr_way][clr_index] <= 1'b0;
            if (fill_done) begin
                valid[victim][miss_index] <= 1'b1;
                dirty[victim][miss_index] <= 1'b0;
                lru[miss_index]           <= ~victim;
            end
        end
    end

    assign cpu_data_rdata   = hit_word;
    assign cpu_data_addr_ok = req_hit;
    assign cpu_data_data_ok = req_hit;
    assign cache_data_req   = state != IDLE && !addr_rcv;
    assign cache_data_wr    = state == WB;
    assign cache_data_size  = 2'b10;
    assign cache_data_addr  = {(state == WB ? tag_mem[victim][miss_index] : miss_tag), miss_index,
                               {OFFSET_WIDTH{1'b0}}} | (32'(k) << 2);
    assign cache_data_wdata = data_mem[victim][miss_addr_w];
endmodule

// File: tb/tb_d_cache_2way_wb.sv
// tb_d_cache_2way_wb: directed checks of the two-way write-back cache against a simple bridge/memory model.
module tb_d_cache_2way_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_data_req, cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
    logic        cache_data_addr_ok, cache_data_data_ok;

    int n_checks = 0;
    int n_fail = 0;

    bit          same = 1'b0;
    logic        pend, pend_wr;
    logic [31:0] pend_addr, pend_wdata;
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata [64];
    logic        log_wr [64];
    int          log_n;

    always #5 clk = ~clk;

    d_cache_2way_wb dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_data_req       (cpu_data_req),
        .cpu_data_wr        (cpu_data_wr),
        .cpu_data_size      (cpu_data_size),
        .cpu_data_addr      (cpu_data_addr),
        .cpu_data_wdata     (cpu_data_wdata),
        .cpu_data_rdata     (cpu_data_rdata),
        .cpu_data_addr_ok   (cpu_data_addr_ok),
        .cpu_data_data_ok   (cpu_data_data_ok),
        .cache_data_req     (cache_data_req),
        .cache_data_wr      (cache_data_wr),
        .cache_data_size    (cache_data_size),
        .cache_data_addr    (cache_data_addr),
        .cache_data_wdata   (cache_data_wdata),
        .cache_data_rdata   (cache_data_rdata),
        .cache_data_addr_ok (cache_data_addr_ok),
        .cache_data_data_ok (cache_data_data_ok)
    );

    // Backing memory: word 0x1000 is preloaded, everything else reads as addr ^ 0xDEAD0000.
    function automatic logic [31:0] ram(input logic [31:0] a);
        return a == 32'h1000 ? 32'h1122_3344 : a ^ 32'hDEAD_0000;
    endfunction

    // Normal mode: addr_ok on request, data_ok one cycle later. Same mode: both in the request cycle.
    assign cache_data_addr_ok = cache_data_req && (same || !pend);
    assign cache_data_data_ok = same ? cache_data_req : pend;
    assign cache_data_rdata   = ram(same ? cache_data_addr : pend_addr);

    always @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            log_n <= 0;
        end else begin
            if ((same ? cache_data_req : pend) && log_n < 64) begin
                log_addr[log_n]  <= same ? cache_data_addr : pend_addr;
                log_wr[log_n]    <= same ? cache_data_wr : pend_wr;
                log_wdata[log_n] <= same ? cache_data_wdata : pend_wdata;
                log_n            <= log_n + 1;
            end
            if (!same) begin
                pend <= !pend && cache_data_req;
                if (cache_data_req && !pend) begin
                    pend_addr  <= cache_data_addr;
                    pend_wr    <= cache_data_wr;
                    pend_wdata <= cache_data_wdata;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        cpu_data_req   = 1'b1;
        cpu_data_wr    = wr;
        cpu_data_size  = size;
        cpu_data_addr  = addr;
        cpu_data_wdata = wdata;
        #1;
        lat = 0;
        while (!cpu_data_data_ok && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, "_dok"}, 32'(cpu_data_data_ok), 32'd1);
        rd = cpu_data_rdata;
        @(posedge clk);
        #1;
        cpu_data_req = 1'b0;
    endtask

    task automatic op_chk(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_lat, input int exp_txn);
        logic [31:0] rd;
        int lat, n0;
        n0 = log_n;
        access(tag, wr, size, addr, wdata, rd, lat);
        if (!wr)
            check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_txn"}, 32'(log_n - n0), 32'(exp_txn));
    endtask

    task automatic log_chk(input string tag, input int first, input logic wr, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_addr[first+i], base + 32'(4*i));
            check($sformatf("%s_wr%0d", tag, i), 32'(log_wr[first+i]), 32'(wr));
        end
    endtask

    initial begin
        logic [31:0] wb_exp [4];
        int n0, t;
        wb_exp = '{32'h1122_AB44, 32'hCAFE_F00D, 32'hDEAD_5A5A, 32'hBEEF_100C};
        rst = 1'b1;
        cpu_data_req = 1'b1;
        cpu_data_wr = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h1004;
        cpu_data_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
        check("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
        check("rst_bus_req", 32'(cache_data_req), 32'd0);
        cpu_data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Cold line fill, then a hit on the same line.
        op_chk("t1_cold", 1'b0, 2'd2, 32'h1004, '0, 32'hDEAD_1004, 9, 4);
        log_chk("t1", 0, 1'b0, 32'h1000);
        check("t1_size", 32'(cache_data_size), 32'd2);
        op_chk("t2_hit", 1'b0, 2'd2, 32'h1008, '0, 32'hDEAD_1008, 0, 0);

        // Store hits of every width, read back through hits.
        op_chk("t3_sb", 1'b1, 2'd0, 32'h1001, 32'h0000_AB00, '0, 0, 0);
        op_chk("t3_lw0", 1'b0, 2'd2, 32'h1000, '0, 32'h1122_AB44, 0, 0);
        op_chk("t3_shu", 1'b1, 2'd1, 32'h100E, 32'hBEEF_0000, '0, 0, 0);
        op_chk("t3_shl", 1'b1, 2'd1, 32'h1008, 32'h0000_5A5A, '0, 0, 0);
        op_chk("t3_sw", 1'b1, 2'd2, 32'h1004, 32'hCAFE_F00D, '0, 0, 0);
        op_chk("t3_lw3", 1'b0, 2'd2, 32'h100C, '0, 32'hBEEF_100C, 0, 0);
        op_chk("t3_lw2", 1'b0, 2'd2, 32'h1008, '0, 32'hDEAD_5A5A, 0, 0);
        op_chk("t3_lw1", 1'b0, 2'd2, 32'h1004, '0, 32'hCAFE_F00D, 0, 0);

        // Set 0: A=0x1000 (dirty), B=0x1800, C=0x2000 evicts A with write-back.
        op_chk("t4_b", 1'b0, 2'd2, 32'h1800, '0, 32'hDEAD_1800, 9, 4);
        n0 = log_n;
        op_chk("t4_c", 1'b0, 2'd2, 32'h2000, '0, 32'hDEAD_2000, 17, 8);
        log_chk("t4_wb", n0, 1'b1, 32'h1000);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_wdata%0d", i), log_wdata[n0+i], wb_exp[i]);
        log_chk("t4_fill", n0 + 4, 1'b0, 32'h2000);
        // Touching B makes C the LRU, so D replaces C and B survives.
        op_chk("t4_touch_b", 1'b0, 2'd2, 32'h1804, '0, 32'hDEAD_1804, 0, 0);
        op_chk("t4_d", 1'b0, 2'd2, 32'h2800, '0, 32'hDEAD_2800, 9, 4);
        op_chk("t4_b_kept", 1'b0, 2'd2, 32'h1808, '0, 32'hDEAD_1808, 0, 0);
        op_chk("t4_c_gone", 1'b0, 2'd2, 32'h2004, '0, 32'hDEAD_2004, 9, 4);

        // Bridge answers addr_ok and data_ok together on every word.
        same = 1'b1;
        n0 = log_n;
        op_chk("t5_fill", 1'b0, 2'd2, 32'h3040, '0, 32'hDEAD_3040, 5, 4);
        log_chk("t5", n0, 1'b0, 32'h3040);
        op_chk("t5_hit", 1'b0, 2'd2, 32'h304C, '0, 32'hDEAD_304C, 0, 0);
        op_chk("t5_swmiss", 1'b1, 2'd2, 32'h3050, 32'h1234_5678, '0, 5, 4);
        op_chk("t5_lw_st", 1'b0, 2'd2, 32'h3050, '0, 32'h1234_5678, 0, 0);
        op_chk("t5_lw_nb", 1'b0, 2'd2, 32'h3054, '0, 32'hDEAD_3054, 0, 0);
        same = 1'b0;

        // Reset while the third fill word is in flight.
        @(negedge clk);
        cpu_data_req  = 1'b1;
        cpu_data_wr   = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h1064;
        n0 = log_n;
        t = 0;
        while (!(log_n == n0 + 2 && pend) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_third_word", 32'(pend), 32'd1);
        rst = 1'b1;
        cpu_data_req = 1'b0;
        @(posedge clk);
        #1;
        check("t6_req_dropped", 32'(cache_data_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op_chk("t6_reload", 1'b0, 2'd2, 32'h1064, '0, 32'hDEAD_1064, 9, 4);
        log_chk("t6", 0, 1'b0, 32'h1060);
        op_chk("t6_cleared", 1'b0, 2'd2, 32'h1004, '0, 32'hDEAD_1004, 9, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
